// File: rtl/csm_sim_axil_pkg.sv
// Shared types and helpers for the CSM simulator AXI4-Lite register slave.
package csm_sim_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT_DATA,
    W_WAIT_ADDR,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    for (int k = 0; k < 4; k++) begin
      merged[8*k +: 8] = strb[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/csm_sim_axil_slave_if.sv
// AXI4-Lite bus bundle between the PS/VIP master and the CSM register slave.
interface csm_sim_axil_slave_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/csm_sim_axil_regbank.sv
// Register storage for the CSM slave: byte-strobed write port, async read mux
// (registers plus status slot) and per-register write strobes.
module csm_sim_axil_regbank
  import csm_sim_axil_pkg::*;
#(
  parameter int          NUM_REGS  = 4,
  parameter int          SW        = 3,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    i_wr_en,
  input  logic [SW-1:0]           i_wr_idx,
  input  logic [31:0]             i_wr_data,
  input  logic [3:0]              i_wr_strb,
  input  logic [SW-1:0]           i_rd_idx,
  output logic [31:0]             o_rd_data,
  input  logic [31:0]             i_status,
  output logic [NUM_REGS*32-1:0]  o_reg_out,
  output logic [NUM_REGS-1:0]     o_reg_wr_pulse
);

  logic [31:0]         r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_wr_pulse;

  // Slot NUM_REGS is the read-only status word, so writes aimed there fall through.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i_wr_en && (int'(i_wr_idx) == i)) begin
          r_regs[i]     <= strb_merge(r_regs[i], i_wr_data, i_wr_strb);
          r_wr_pulse[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    if (int'(i_rd_idx) == NUM_REGS) o_rd_data = i_status;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(i_rd_idx) == i) o_rd_data = r_regs[i];
    end
  end

  always_comb begin
    o_reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) o_reg_out[32*i +: 32] = r_regs[i];
  end

  assign o_reg_wr_pulse = r_wr_pulse;

endmodule

// File: rtl/csm_sim_axil_slave.sv
// AXI4-Lite slave exposing the CSM simulator control/status registers.
// Define CSM_AXIL_DECERR_EN to answer out-of-map accesses with DECERR instead of aliasing.
module csm_sim_axil_slave
  import csm_sim_axil_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter int          NUM_REGS           = 4,
  parameter logic [31:0] RESET_VAL          = 32'h0
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  csm_sim_axil_slave_if.slave    s_axi,
  input  logic [31:0]            status_in,
  output logic [NUM_REGS*32-1:0] reg_out,
  output logic [NUM_REGS-1:0]    reg_wr_pulse
);

  localparam int          IW    = C_S_AXI_ADDR_WIDTH - 2;
  localparam int          SW    = $clog2(NUM_REGS + 1);
  localparam int unsigned SLOTS = NUM_REGS + 1;

  // Returns {decode_error, slot}; slot NUM_REGS is the status word.
  function automatic logic [SW:0] map_idx(input logic [IW-1:0] idx);
    logic [31:0] wide;
    wide = 32'(idx);
`ifdef CSM_AXIL_DECERR_EN
    if (wide > 32'(NUM_REGS)) return {1'b1, {SW{1'b0}}};
    return {1'b0, SW'(wide)};
`else
    return {1'b0, SW'(wide % 32'(SLOTS))};
`endif
  endfunction

  wstate_e                 r_wstate, w_wstate_nxt;
  rstate_e                 r_rstate, w_rstate_nxt;
  logic [IW-1:0]           r_awidx;
  logic [31:0]             r_wdata;
  logic [3:0]              r_wstrb;
  logic [1:0]              r_bresp;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]              r_rresp;

  logic                    w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
  logic                    w_commit, w_lat_aw, w_lat_w, w_ar_hs;
  logic [IW-1:0]           w_cmt_idx, w_aw_idx, w_ar_idx;
  logic [31:0]             w_cmt_data;
  logic [3:0]              w_cmt_strb;
  logic [SW:0]             w_wmap, w_rmap;
  logic [31:0]             w_rd_data;
  logic                    w_unused;

  assign w_aw_idx = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_ar_idx = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                      s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  // Write channel: AW and W may arrive in either order; the later one commits.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_awready    = 1'b0;
    w_wready     = 1'b0;
    w_bvalid     = 1'b0;
    w_commit     = 1'b0;
    w_lat_aw     = 1'b0;
    w_lat_w      = 1'b0;
    w_cmt_idx    = r_awidx;
    w_cmt_data   = r_wdata;
    w_cmt_strb   = r_wstrb;
    case (r_wstate)
      W_IDLE: begin
        w_awready = 1'b1;
        w_wready  = 1'b1;
        if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
          w_commit     = 1'b1;
          w_cmt_idx    = w_aw_idx;
          w_cmt_data   = s_axi.S_AXI_WDATA;
          w_cmt_strb   = s_axi.S_AXI_WSTRB;
          w_wstate_nxt = W_RESP;
        end else if (s_axi.S_AXI_AWVALID) begin
          w_lat_aw     = 1'b1;
          w_wstate_nxt = W_WAIT_DATA;
        end else if (s_axi.S_AXI_WVALID) begin
          w_lat_w      = 1'b1;
          w_wstate_nxt = W_WAIT_ADDR;
        end
      end
      W_WAIT_DATA: begin
        w_wready = 1'b1;
        if (s_axi.S_AXI_WVALID) begin
          w_commit     = 1'b1;
          w_cmt_data   = s_axi.S_AXI_WDATA;
          w_cmt_strb   = s_axi.S_AXI_WSTRB;
          w_wstate_nxt = W_RESP;
        end
      end
      W_WAIT_ADDR: begin
        w_awready = 1'b1;
        if (s_axi.S_AXI_AWVALID) begin
          w_commit     = 1'b1;
          w_cmt_idx    = w_aw_idx;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (s_axi.S_AXI_BREADY) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  assign w_wmap = map_idx(w_cmt_idx);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_awidx <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_bresp <= RESP_OKAY;
    end else begin
      if (w_lat_aw) r_awidx <= w_aw_idx;
      if (w_lat_w) begin
        r_wdata <= s_axi.S_AXI_WDATA;
        r_wstrb <= s_axi.S_AXI_WSTRB;
      end
      if (w_commit) r_bresp <= w_wmap[SW] ? RESP_DECERR : RESP_OKAY;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_arready    = 1'b0;
    w_rvalid     = 1'b0;
    w_ar_hs      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        w_arready = 1'b1;
        if (s_axi.S_AXI_ARVALID) begin
          w_ar_hs      = 1'b1;
          w_rstate_nxt = R_DATA;
        end
      end
      R_DATA: begin
        w_rvalid = 1'b1;
        if (s_axi.S_AXI_RREADY) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  assign w_rmap = map_idx(w_ar_idx);

  // Captured on the same edge a write may commit, so a colliding read sees old data.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rmap[SW] ? '0 : w_rd_data;
      r_rresp <= w_rmap[SW] ? RESP_DECERR : RESP_OKAY;
    end
  end

  csm_sim_axil_regbank #(
    .NUM_REGS  (NUM_REGS),
    .SW        (SW),
    .RESET_VAL (RESET_VAL)
  ) u_regbank (
    .ACLK           (ACLK),
    .ARESET         (ARESET),
    .i_wr_en        (w_commit & ~w_wmap[SW]),
    .i_wr_idx       (w_wmap[SW-1:0]),
    .i_wr_data      (w_cmt_data),
    .i_wr_strb      (w_cmt_strb),
    .i_rd_idx       (w_rmap[SW-1:0]),
    .o_rd_data      (w_rd_data),
    .i_status       (status_in),
    .o_reg_out      (reg_out),
    .o_reg_wr_pulse (reg_wr_pulse)
  );

  assign s_axi.S_AXI_AWREADY = w_awready;
  assign s_axi.S_AXI_WREADY  = w_wready;
  assign s_axi.S_AXI_BVALID  = w_bvalid;
  assign s_axi.S_AXI_BRESP   = r_bresp;
  assign s_axi.S_AXI_ARREADY = w_arready;
  assign s_axi.S_AXI_RVALID  = w_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = r_rresp;

endmodule

// File: tb/tb_csm_sim_axil_slave.sv
// Randomized self-checking bench for csm_sim_axil_slave against a register-map model.
module tb_csm_sim_axil_slave;

  logic        clk;
  logic        rst;
  logic [31:0] status_in;
  logic [127:0] reg_out;
  logic [3:0]  reg_wr_pulse;

  int checks;
  int failures;

  logic [31:0] m_regs [4];

  csm_sim_axil_slave_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) axi ();

  csm_sim_axil_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (5),
    .NUM_REGS           (4),
    .RESET_VAL          (32'h0)
  ) dut (
    .ACLK         (clk),
    .ARESET       (rst),
    .s_axi        (axi),
    .status_in    (status_in),
    .reg_out      (reg_out),
    .reg_wr_pulse (reg_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] model_flat();
    return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  // Word index addr[4:2]; index 4 is status, beyond that depends on the build option.
  task automatic model_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output logic [3:0] pulse);
    int idx;
    int slot;
    idx   = int'(addr[4:2]);
    resp  = 2'b00;
    pulse = 4'b0000;
`ifdef CSM_AXIL_DECERR_EN
    if (idx > 4) begin
      resp = 2'b11;
      slot = 99;
    end else slot = idx;
`else
    slot = idx % 5;
`endif
    if (slot < 4) begin
      for (int k = 0; k < 4; k++)
        if (strb[k]) m_regs[slot][8*k +: 8] = data[8*k +: 8];
      pulse[slot] = 1'b1;
    end
  endtask

  task automatic model_read(input logic [4:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
    int idx;
    int slot;
    idx  = int'(addr[4:2]);
    resp = 2'b00;
    data = 32'h0;
`ifdef CSM_AXIL_DECERR_EN
    if (idx > 4) begin
      resp = 2'b11;
      slot = 99;
    end else slot = idx;
`else
    slot = idx % 5;
`endif
    if (slot < 4) data = m_regs[slot];
    else if (slot == 4) data = status_in;
  endtask

  // Called on a negedge; returns on a negedge after the B handshake.
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    logic [1:0] exp_resp;
    logic [3:0] exp_pulse;
    aw_done = 0; w_done = 0; cyc = 0;
    model_write(addr, data, strb, exp_resp, exp_pulse);
    while (!(aw_done && w_done) && cyc < 40) begin
      axi.S_AXI_AWADDR  = addr;
      axi.S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      axi.S_AXI_WDATA   = data;
      axi.S_AXI_WSTRB   = strb;
      axi.S_AXI_WVALID  = !w_done && (cyc >= w_dly);
      #1;
      if (aw_done && !w_done) begin
        checks++;
        if (axi.S_AXI_AWREADY !== 1'b0) begin
          failures++;
          $display("FAIL awready_hold: got %b want 0", axi.S_AXI_AWREADY);
        end
      end
      if (w_done && !aw_done) begin
        checks++;
        if (axi.S_AXI_WREADY !== 1'b0) begin
          failures++;
          $display("FAIL wready_hold: got %b want 0", axi.S_AXI_WREADY);
        end
      end
      aw_hs = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      w_hs  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      @(posedge clk);
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
      @(negedge clk);
      cyc++;
    end
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    checks++;
    if (!(aw_done && w_done)) begin
      failures++;
      $display("FAIL write_accept_timeout: addr=%h aw=%0b w=%0b", addr, aw_done, w_done);
      return;
    end
    checks++;
    if (axi.S_AXI_BVALID !== 1'b1 || axi.S_AXI_BRESP !== exp_resp) begin
      failures++;
      $display("FAIL b_latency: bvalid=%b bresp=%b want 1/%b", axi.S_AXI_BVALID,
               axi.S_AXI_BRESP, exp_resp);
    end
    checks++;
    if (reg_wr_pulse !== exp_pulse || reg_out !== model_flat()) begin
      failures++;
      $display("FAIL commit: pulse=%b want %b reg_out=%h want %h", reg_wr_pulse,
               exp_pulse, reg_out, model_flat());
    end
    for (int i = 0; i < b_dly; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (axi.S_AXI_BVALID !== 1'b1 || axi.S_AXI_BRESP !== exp_resp ||
          axi.S_AXI_AWREADY !== 1'b0 || axi.S_AXI_WREADY !== 1'b0 ||
          reg_wr_pulse !== 4'b0) begin
        failures++;
        $display("FAIL b_hold: bvalid=%b bresp=%b awr=%b wr=%b pulse=%b want 1/%b/0/0/0",
                 axi.S_AXI_BVALID, axi.S_AXI_BRESP, axi.S_AXI_AWREADY,
                 axi.S_AXI_WREADY, reg_wr_pulse, exp_resp);
      end
    end
    axi.S_AXI_BREADY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi.S_AXI_BREADY = 1'b0;
    checks++;
    if (axi.S_AXI_BVALID !== 1'b0 || reg_wr_pulse !== 4'b0) begin
      failures++;
      $display("FAIL b_done: bvalid=%b pulse=%b want 0/0", axi.S_AXI_BVALID, reg_wr_pulse);
    end
  endtask

  // Called on a negedge; returns captured RDATA/RRESP on a negedge after the R handshake.
  task automatic axi_read(input logic [4:0] addr, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    bit done;
    int cyc;
    done = 0; cyc = 0;
    data = 32'hxxxxxxxx; resp = 2'bxx;
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    while (!done && cyc < 40) begin
      #1;
      if (axi.S_AXI_ARREADY === 1'b1) done = 1;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    axi.S_AXI_ARVALID = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL read_accept_timeout: addr=%h", addr);
      return;
    end
    checks++;
    if (axi.S_AXI_RVALID !== 1'b1) begin
      failures++;
      $display("FAIL r_latency: rvalid=%b want 1", axi.S_AXI_RVALID);
    end
    data = axi.S_AXI_RDATA;
    resp = axi.S_AXI_RRESP;
    for (int i = 0; i < r_dly; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (axi.S_AXI_RVALID !== 1'b1 || axi.S_AXI_RDATA !== data ||
          axi.S_AXI_RRESP !== resp || axi.S_AXI_ARREADY !== 1'b0) begin
        failures++;
        $display("FAIL r_hold: rvalid=%b rdata=%h rresp=%b arready=%b want 1/%h/%b/0",
                 axi.S_AXI_RVALID, axi.S_AXI_RDATA, axi.S_AXI_RRESP,
                 axi.S_AXI_ARREADY, data, resp);
      end
    end
    axi.S_AXI_RREADY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi.S_AXI_RREADY = 1'b0;
    checks++;
    if (axi.S_AXI_RVALID !== 1'b0) begin
      failures++;
      $display("FAIL r_done: rvalid=%b want 0", axi.S_AXI_RVALID);
    end
  endtask

  task automatic check_read(input string name, input logic [4:0] addr, input int r_dly);
    logic [31:0] got_d, exp_d;
    logic [1:0]  got_r, exp_r;
    model_read(addr, exp_d, exp_r);
    axi_read(addr, r_dly, got_d, got_r);
    checks++;
    if (got_d !== exp_d || got_r !== exp_r) begin
      failures++;
      $display("FAIL %s: addr=%h rdata=%h rresp=%b want %h/%b", name, addr, got_d, got_r,
               exp_d, exp_r);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (axi.S_AXI_AWREADY !== 1'b1 || axi.S_AXI_WREADY !== 1'b1 ||
        axi.S_AXI_ARREADY !== 1'b1 || axi.S_AXI_BVALID !== 1'b0 ||
        axi.S_AXI_RVALID !== 1'b0 || axi.S_AXI_BRESP !== 2'b00 ||
        axi.S_AXI_RRESP !== 2'b00 || axi.S_AXI_RDATA !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus: awr=%b wr=%b arr=%b bv=%b rv=%b br=%b rr=%b rd=%h",
               axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY, axi.S_AXI_BVALID,
               axi.S_AXI_RVALID, axi.S_AXI_BRESP, axi.S_AXI_RRESP, axi.S_AXI_RDATA);
    end
    checks++;
    if (reg_out !== 128'h0 || reg_wr_pulse !== 4'b0) begin
      failures++;
      $display("FAIL reset_regs: reg_out=%h pulse=%b want 0/0", reg_out, reg_wr_pulse);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++)
      axi_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      check_read("seq_readback", 5'(4 * i), 0);
    checks++;
    if (reg_out !== {32'h4, 32'h3, 32'h2, 32'h1}) begin
      failures++;
      $display("FAIL seq_reg_out: got %h want 4/3/2/1", reg_out);
    end
  endtask

  task automatic test_split_order();
    axi_write(5'h08, 32'hDEADBEEF, 4'hF, 0, 3, 0);
    axi_write(5'h04, 32'h12345678, 4'hF, 2, 0, 0);
    checks++;
    if (reg_out[95:64] !== 32'hDEADBEEF || reg_out[63:32] !== 32'h12345678) begin
      failures++;
      $display("FAIL split_order: reg2=%h reg1=%h want deadbeef/12345678",
               reg_out[95:64], reg_out[63:32]);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(5'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_write(5'h00, 32'h00000000, 4'b0101, 0, 0, 0);
    axi_read(5'h00, 0, d, r);
    checks++;
    if (d !== 32'hFF00FF00 || r !== 2'b00) begin
      failures++;
      $display("FAIL strobe_merge: got %h/%b want ff00ff00/00", d, r);
    end
    axi_write(5'h00, 32'h5A5A5A5A, 4'b0000, 0, 0, 0);
    check_read("strobe_zero", 5'h00, 0);
  endtask

  task automatic test_backpressure();
    axi_write(5'h0C, 32'hA5A55A5A, 4'hF, 0, 0, 10);
    check_read("backpressure_read", 5'h0C, 10);
  endtask

  task automatic test_status_map();
    status_in = 32'hCAFE0001;
    check_read("status_read", 5'h10, 0);
    check_read("beyond_status_read", 5'h18, 1);
    axi_write(5'h10, 32'h11111111, 4'hF, 0, 0, 0);
    axi_write(5'h1C, 32'h77777777, 4'hF, 1, 0, 0);
    check_read("beyond_after_write", 5'h1F, 0);
    check_read("reg2_after_write", 5'h08, 0);
  endtask

  task automatic test_simultaneous_rw();
    logic [31:0] old_v, got_d;
    logic [1:0]  got_r;
    old_v = m_regs[1];
    fork
      axi_write(5'h04, old_v ^ 32'hFFFF0000, 4'hF, 0, 0, 0);
      axi_read(5'h04, 0, got_d, got_r);
    join
    checks++;
    if (got_d !== old_v || got_r !== 2'b00) begin
      failures++;
      $display("FAIL simultaneous_rw: got %h/%b want %h/00", got_d, got_r, old_v);
    end
    check_read("simultaneous_after", 5'h04, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 0)
        axi_write(5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)));
      else
        check_read("random_read", 5'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_reset_mid();
    axi.S_AXI_AWADDR  = 5'h04;
    axi.S_AXI_WDATA   = 32'h0BADF00D;
    axi.S_AXI_WSTRB   = 4'hF;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    checks++;
    if (axi.S_AXI_BVALID !== 1'b1) begin
      failures++;
      $display("FAIL mid_resp_state: bvalid=%b want 1", axi.S_AXI_BVALID);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (axi.S_AXI_BVALID !== 1'b0 || axi.S_AXI_AWREADY !== 1'b1 || reg_out !== 128'h0) begin
      failures++;
      $display("FAIL async_reset: bvalid=%b awready=%b reg_out=%h want 0/1/0",
               axi.S_AXI_BVALID, axi.S_AXI_AWREADY, reg_out);
    end
    for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    axi_write(5'h00, 32'h600DCAFE, 4'hF, 0, 0, 0);
    check_read("post_reset_read", 5'h00, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
    rst = 1'b1;
    status_in = 32'h0;
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA  = '0; axi.S_AXI_WSTRB  = '0; axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_split_order();
    test_strobe();
    test_backpressure();
    test_status_map();
    test_simultaneous_rw();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
